// File: rtl/ram_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_loader_ctrl
// Brief    : Boot-time program loader. Takes bytes from a valid/ready source
//            and writes them to consecutive RAM addresses using the MAR-then-
//            RAM set sequence, holding the CPU in reset until the image is in.
// Revision : 1.0 - initial release
// ============================================================================
module ram_loader_ctrl #(
  parameter int START_ADDR = 0,
  parameter int LOAD_COUNT = 256
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic [7:0] load_bus,
  output logic       load_bus_en,
  output logic       s_MAR,
  output logic       s_RAM,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic [7:0] addr
);

  localparam int         c_last_index = LOAD_COUNT - 1;
  localparam logic [7:0] c_start_addr = START_ADDR[7:0];
  // Byte index of the final byte; count stays within 0..255 so 8 bits suffice.
  localparam logic [7:0] c_last_count = c_last_index[7:0];

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_A_SETUP = 3'd2,
    S_A_SET   = 3'd3,
    S_D_SETUP = 3'd4,
    S_D_SET   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t     r_state,  w_state_next;
  logic [7:0] r_addr,   w_addr_next;
  logic [7:0] r_count,  w_count_next;
  logic [7:0] r_data,   w_data_next;

  logic       r_byte_ready, w_byte_ready_next;
  logic [7:0] r_load_bus,   w_load_bus_next;
  logic       r_load_bus_en, w_load_bus_en_next;
  logic       r_s_mar,      w_s_mar_next;
  logic       r_s_ram,      w_s_ram_next;
  logic       r_cpu_hold,   w_cpu_hold_next;
  logic       r_busy,       w_busy_next;
  logic       r_done,       w_done_next;

  // Next-state, address, byte counter and data latch sequencing.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_count_next = r_count;
    w_data_next  = r_data;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_WAIT;
          w_addr_next  = c_start_addr;
          w_count_next = 8'd0;
        end
      end
      S_WAIT: begin
        // byte_ready is high exactly in WAIT, so this is the handshake.
        if (byte_valid && r_byte_ready) begin
          w_data_next  = byte_data;
          w_state_next = S_A_SETUP;
        end
      end
      S_A_SETUP: w_state_next = S_A_SET;
      S_A_SET:   w_state_next = S_D_SETUP;
      S_D_SETUP: w_state_next = S_D_SET;
      S_D_SET: begin
        w_addr_next  = r_addr + 8'd1;
        w_count_next = r_count + 8'd1;
        w_state_next = (r_count == c_last_count) ? S_DONE : S_WAIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore output decode from the upcoming state so outputs register alongside it.
  always_comb begin
    w_byte_ready_next  = (w_state_next == S_WAIT);
    w_busy_next        = (w_state_next == S_WAIT)    || (w_state_next == S_A_SETUP) ||
                         (w_state_next == S_A_SET)   || (w_state_next == S_D_SETUP) ||
                         (w_state_next == S_D_SET);
    w_load_bus_en_next = (w_state_next == S_A_SETUP) || (w_state_next == S_A_SET) ||
                         (w_state_next == S_D_SETUP) || (w_state_next == S_D_SET);
    w_load_bus_next    = 8'h00;
    case (w_state_next)
      S_A_SETUP, S_A_SET: w_load_bus_next = w_addr_next;
      S_D_SETUP, S_D_SET: w_load_bus_next = w_data_next;
      default:            w_load_bus_next = 8'h00;
    endcase
    w_s_mar_next    = (w_state_next == S_A_SET);
    w_s_ram_next    = (w_state_next == S_D_SET);
    w_cpu_hold_next = (w_state_next != S_DONE);
    w_done_next     = (w_state_next == S_DONE);
  end

  // State, datapath and output registers; reset aborts any load in progress.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_addr        <= c_start_addr;
      r_count       <= 8'd0;
      r_data        <= 8'h00;
      r_byte_ready  <= 1'b0;
      r_load_bus    <= 8'h00;
      r_load_bus_en <= 1'b0;
      r_s_mar       <= 1'b0;
      r_s_ram       <= 1'b0;
      r_cpu_hold    <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_addr        <= w_addr_next;
      r_count       <= w_count_next;
      r_data        <= w_data_next;
      r_byte_ready  <= w_byte_ready_next;
      r_load_bus    <= w_load_bus_next;
      r_load_bus_en <= w_load_bus_en_next;
      r_s_mar       <= w_s_mar_next;
      r_s_ram       <= w_s_ram_next;
      r_cpu_hold    <= w_cpu_hold_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
    end
  end

  assign byte_ready  = r_byte_ready;
  assign load_bus    = r_load_bus;
  assign load_bus_en = r_load_bus_en;
  assign s_MAR       = r_s_mar;
  assign s_RAM       = r_s_ram;
  assign cpu_hold    = r_cpu_hold;
  assign busy        = r_busy;
  assign done        = r_done;
  assign addr        = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_loader_ctrl
// Brief    : Self-checking bench for ram_loader_ctrl. Two instances (start at
//            0x10 / 4 bytes, start at 0xFE / 3 bytes) share the byte source;
//            a RAM model plus expected-write queue checks every s_RAM pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_loader_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       sel_b = 1'b0;

  logic       a_ready, a_en, a_mar, a_ram, a_hold, a_busy, a_done;
  logic [7:0] a_bus, a_addr;
  logic       b_ready, b_en, b_mar, b_ram, b_hold, b_busy, b_done;
  logic [7:0] b_bus, b_addr;

  ram_loader_ctrl #(.START_ADDR(16), .LOAD_COUNT(4)) u_dut_a (
    .sys_clk(clk), .reset(reset), .start(start_a), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(a_ready), .load_bus(a_bus),
    .load_bus_en(a_en), .s_MAR(a_mar), .s_RAM(a_ram), .cpu_hold(a_hold),
    .busy(a_busy), .done(a_done), .addr(a_addr)
  );

  ram_loader_ctrl #(.START_ADDR(254), .LOAD_COUNT(3)) u_dut_b (
    .sys_clk(clk), .reset(reset), .start(start_b), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(b_ready), .load_bus(b_bus),
    .load_bus_en(b_en), .s_MAR(b_mar), .s_RAM(b_ram), .cpu_hold(b_hold),
    .busy(b_busy), .done(b_done), .addr(b_addr)
  );

  // Observed instance selected by sel_b
  logic       m_ready, m_en, m_mar, m_ram, m_hold, m_busy, m_done;
  logic [7:0] m_bus, m_addr;
  assign m_ready = sel_b ? b_ready : a_ready;
  assign m_en    = sel_b ? b_en    : a_en;
  assign m_mar   = sel_b ? b_mar   : a_mar;
  assign m_ram   = sel_b ? b_ram   : a_ram;
  assign m_hold  = sel_b ? b_hold  : a_hold;
  assign m_busy  = sel_b ? b_busy  : a_busy;
  assign m_done  = sel_b ? b_done  : a_done;
  assign m_bus   = sel_b ? b_bus   : a_bus;
  assign m_addr  = sel_b ? b_addr  : a_addr;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] ram [0:255];
  logic [7:0] mar = 8'h00;
  logic [7:0] img [0:7];
  int total = 0;
  int bad = 0;
  int mar_pulses = 0;
  int ram_pulses = 0;

  // Bus monitor / scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (m_mar) begin
        mar = m_bus;
        mar_pulses++;
      end
      if (m_mar || m_ram) begin
        total++;
        if ((m_mar && m_ram) || !m_en || !m_busy) begin
          bad++;
          $display("FAIL strobe_state: mar=%0b ram=%0b bus_en=%0b busy=%0b required single strobe with bus_en=1 busy=1",
                   m_mar, m_ram, m_en, m_busy);
        end
      end
      if (m_ready) begin
        total++;
        if (m_en || !m_busy || m_mar || m_ram) begin
          bad++;
          $display("FAIL ready_state: bus_en=%0b busy=%0b mar=%0b ram=%0b required 0/1/0/0 while ready",
                   m_en, m_busy, m_mar, m_ram);
        end
      end
      if (!m_en) begin
        total++;
        if (m_bus !== 8'h00) begin
          bad++;
          $display("FAIL bus_released: load_bus=%h required 00", m_bus);
        end
      end
      if (m_ram) begin
        ram_pulses++;
        ram[mar] = m_bus;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%h data=%h required no write", mar, m_bus);
        end else begin
          e = exp_q.pop_front();
          if (mar !== e.addr || m_bus !== e.data) begin
            bad++;
            $display("FAIL ram_write: addr=%h data=%h required addr=%h data=%h", mar, m_bus, e.addr, e.data);
          end
        end
      end
    end
  end

  // Pulse start on the selected instance; returns on the first WAIT-cycle falling edge.
  task automatic kick();
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Feed img[0..n-1]; pushes expected writes on each handshake. Stops at done,
  // after stop_after s_RAM pulses (if >0), or on the cycle budget.
  task automatic feed(input int n, input bit rnd, input int stop_after, input bit poke,
                      output int cycles, output bit timeout);
    int         idx;
    int         seen;
    logic [7:0] a;
    wr_t        e;
    idx = 0;
    seen = 0;
    a = sel_b ? 8'hFE : 8'h10;
    cycles = 0;
    timeout = 1'b0;
    forever begin
      if (m_ram) seen++;
      if (m_done) break;
      if (stop_after > 0 && seen == stop_after) break;
      if (cycles > 400) begin
        timeout = 1'b1;
        break;
      end
      byte_valid = (idx < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      byte_data  = (idx < n) ? img[idx] : 8'h00;
      if (sel_b) start_b = poke && (cycles == 7); else start_a = poke && (cycles == 7);
      if (byte_valid && m_ready) begin
        e.addr = a;
        e.data = byte_data;
        exp_q.push_back(e);
        a++;
        idx++;
      end
      @(negedge clk);
      cycles++;
    end
    byte_valid = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({a_ready, a_en, a_mar, a_ram, a_hold, a_busy, a_done, a_bus, a_addr} !==
          {7'b0000100, 8'h00, 8'h10}) begin
        bad++;
        $display("FAIL reset_idle_a: rdy/en/mar/ram/hold/busy/done=%b bus=%h addr=%h required 0000100 00 10",
                 {a_ready, a_en, a_mar, a_ram, a_hold, a_busy, a_done}, a_bus, a_addr);
      end
    end
    total++;
    if ({b_ready, b_en, b_mar, b_ram, b_hold, b_busy, b_done, b_bus, b_addr} !==
        {7'b0000100, 8'h00, 8'hFE}) begin
      bad++;
      $display("FAIL reset_idle_b: flags=%b bus=%h addr=%h required 0000100 00 fe",
               {b_ready, b_en, b_mar, b_ram, b_hold, b_busy, b_done}, b_bus, b_addr);
    end
  endtask

  task automatic test_basic_load();
    int cyc;
    bit to;
    int m0;
    int r0;
    sel_b = 1'b0;
    img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3; img[3] = 8'hD4;
    m0 = mar_pulses;
    r0 = ram_pulses;
    kick();
    total++;
    if ({m_busy, m_ready, m_hold, m_done} !== 4'b1110) begin
      bad++;
      $display("FAIL load_first_wait: busy/ready/hold/done=%b required 1110", {m_busy, m_ready, m_hold, m_done});
    end
    feed(4, 1'b0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 20) begin
      bad++;
      $display("FAIL load_latency: cycles=%0d timeout=%0b required 20 cycles", cyc, to);
    end
    total++;
    if ({m_done, m_hold, m_busy, m_ready, m_en, m_addr} !== {5'b10000, 8'h14}) begin
      bad++;
      $display("FAIL load_done_state: done/hold/busy/ready/en=%b addr=%h required 10000 14",
               {m_done, m_hold, m_busy, m_ready, m_en}, m_addr);
    end
    total++;
    if (mar_pulses - m0 != 4 || ram_pulses - r0 != 4) begin
      bad++;
      $display("FAIL load_pulses: mar=%0d ram=%0d required 4 and 4", mar_pulses - m0, ram_pulses - r0);
    end
    total++;
    if ({ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== 32'hA1B2C3D4) begin
      bad++;
      $display("FAIL load_ram: ram[10..13]=%h%h%h%h required a1b2c3d4",
               ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]);
    end
    // Source keeps offering data in DONE: nothing may be accepted.
    r0 = ram_pulses;
    byte_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      total++;
      if (m_ready || !m_done || m_hold) begin
        bad++;
        $display("FAIL done_hold: ready=%0b done=%0b hold=%0b required 0 1 0", m_ready, m_done, m_hold);
      end
    end
    byte_valid = 1'b0;
    total++;
    if (ram_pulses != r0) begin
      bad++;
      $display("FAIL done_no_write: writes=%0d required 0", ram_pulses - r0);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit to;
    sel_b = 1'b1;
    img[0] = 8'h5A; img[1] = 8'h6B; img[2] = 8'h7C;
    kick();
    feed(3, 1'b0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 15) begin
      bad++;
      $display("FAIL wrap_latency: cycles=%0d timeout=%0b required 15", cyc, to);
    end
    total++;
    if ({ram[8'hFE], ram[8'hFF], ram[8'h00]} !== 24'h5A6B7C) begin
      bad++;
      $display("FAIL wrap_ram: ram[fe,ff,00]=%h %h %h required 5a 6b 7c", ram[8'hFE], ram[8'hFF], ram[8'h00]);
    end
    total++;
    if (m_addr !== 8'h01 || m_done !== 1'b1 || m_hold !== 1'b0) begin
      bad++;
      $display("FAIL wrap_done: addr=%h done=%0b hold=%0b required 01 1 0", m_addr, m_done, m_hold);
    end
    sel_b = 1'b0;
  endtask

  task automatic test_random_valid();
    int cyc;
    bit to;
    int r0;
    sel_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) img[j] = 8'($urandom_range(0, 255));
      r0 = ram_pulses;
      kick();
      feed(4, 1'b1, 0, 1'b0, cyc, to);
      total++;
      if (to || cyc < 20 || ram_pulses - r0 != 4 || !m_done) begin
        bad++;
        $display("FAIL random_load: cycles=%0d timeout=%0b writes=%0d done=%0b required >=20 0 4 1",
                 cyc, to, ram_pulses - r0, m_done);
      end
      total++;
      if ({ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== {img[0], img[1], img[2], img[3]}) begin
        bad++;
        $display("FAIL random_ram: ram=%h%h%h%h required %h%h%h%h", ram[8'h10], ram[8'h11],
                 ram[8'h12], ram[8'h13], img[0], img[1], img[2], img[3]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int cyc;
    bit to;
    sel_b = 1'b0;
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    kick();
    feed(4, 1'b0, 2, 1'b0, cyc, to);
    total++;
    if (to || m_ram !== 1'b1) begin
      bad++;
      $display("FAIL midload_dset: s_RAM=%0b timeout=%0b required 1 0", m_ram, to);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if ({m_ram, m_mar, m_hold, m_busy, m_ready, m_en, m_done, m_addr} !== {7'b0010000, 8'h10}) begin
      bad++;
      $display("FAIL midload_abort: ram/mar/hold/busy/ready/en/done=%b addr=%h required 0010000 10",
               {m_ram, m_mar, m_hold, m_busy, m_ready, m_en, m_done}, m_addr);
    end
    reset = 1'b0;
    exp_q.delete();
    img[0] = 8'h91; img[1] = 8'h92; img[2] = 8'h93; img[3] = 8'h94;
    kick();
    feed(4, 1'b0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 20 || {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== 32'h91929394) begin
      bad++;
      $display("FAIL midload_reload: cycles=%0d ram=%h%h%h%h required 20 91929394",
               cyc, ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    sel_b = 1'b0;
    img[0] = 8'hE1; img[1] = 8'hE2; img[2] = 8'hE3; img[3] = 8'hE4;
    kick();
    feed(4, 1'b0, 0, 1'b1, cyc, to);
    total++;
    if (to || cyc != 20 || !m_done) begin
      bad++;
      $display("FAIL busy_start_ignored: cycles=%0d done=%0b required 20 1", cyc, m_done);
    end
    img[0] = 8'hF1; img[1] = 8'hF2; img[2] = 8'hF3; img[3] = 8'hF4;
    kick();
    total++;
    if ({m_done, m_hold, m_busy} !== 3'b011) begin
      bad++;
      $display("FAIL restart_from_done: done/hold/busy=%b required 011", {m_done, m_hold, m_busy});
    end
    feed(4, 1'b0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 20 || !m_done ||
        {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== 32'hF1F2F3F4) begin
      bad++;
      $display("FAIL second_load: cycles=%0d done=%0b ram=%h%h%h%h required 20 1 f1f2f3f4",
               cyc, m_done, ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset();
    test_basic_load();
    test_wrap();
    test_random_valid();
    test_reset_midload();
    test_back_to_back();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_writes: outstanding=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
